// File: rtl/alu_op_sequencer_if.sv
// Bundle between the test harness (master) and the ALU op sequencer (slave).
// The step signal exists only when ALU_SEQ_STEP_EN is defined.
interface alu_op_sequencer_if #(
   parameter int FUNC_W = 4,
   parameter int RA_W   = 4,
   parameter int DEPTH  = 16,
   parameter int PC_W   = $clog2(DEPTH)
);
   localparam int INSTR_W = FUNC_W + 3*RA_W;

   // Handshake: the caller raises start for one cycle while busy=0; busy stays
   // high for the whole run and done pulses for one cycle once it has finished.
   logic               prog_we;
   logic [PC_W-1:0]    prog_addr;
   logic [INSTR_W-1:0] prog_data;
   logic [PC_W:0]      prog_len;
   logic               start;
`ifdef ALU_SEQ_STEP_EN
   logic               step;
`endif
   logic               busy;
   logic               done;
   logic [PC_W-1:0]    pc;
   logic [FUNC_W-1:0]  alu_func;
   logic [RA_W-1:0]    rd_addr;
   logic [RA_W-1:0]    rs1_addr;
   logic [RA_W-1:0]    rs2_addr;
   logic               reg_we;
   logic [2:0]         fsm_state;

   modport master (
`ifdef ALU_SEQ_STEP_EN
      output step,
`endif
      output prog_we, prog_addr, prog_data, prog_len, start,
      input  busy, done, pc, alu_func, rd_addr, rs1_addr, rs2_addr, reg_we, fsm_state
   );

   modport slave (
`ifdef ALU_SEQ_STEP_EN
      input  step,
`endif
      input  prog_we, prog_addr, prog_data, prog_len, start,
      output busy, done, pc, alu_func, rd_addr, rs1_addr, rs2_addr, reg_we, fsm_state
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Loadable-program micro-sequencer driving REG_BANK addresses and K_ALU_32 function codes.
// Optional single-step gating between instructions is enabled by defining ALU_SEQ_STEP_EN.
module alu_op_sequencer #(
   parameter int                FUNC_W    = 4,
   parameter int                RA_W      = 4,
   parameter int                DEPTH     = 16,
   parameter int                PC_W      = $clog2(DEPTH),
   parameter logic [FUNC_W-1:0] HALT_FUNC = 4'b1111
) (
   input logic               clk,
   input logic               rst,
   alu_op_sequencer_if.slave bus
);
   localparam int INSTR_W = FUNC_W + 3*RA_W;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_WB    = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [INSTR_W-1:0] mem [DEPTH];
   logic [INSTR_W-1:0] ir;
   logic [PC_W-1:0]    pc_q;
   logic [PC_W:0]      len_q;
   logic               reg_we_q;
   logic               busy;
   logic               is_halt;
   logic               last;
   logic               step_ok;
   logic               launch;

`ifdef ALU_SEQ_STEP_EN
   assign step_ok = bus.step;
`else
   assign step_ok = 1'b1;
`endif

   assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WB);
   assign is_halt = (ir[INSTR_W-1 -: FUNC_W] == HALT_FUNC);
   // len_q is never 0 inside a run, so len_q-1 cannot underflow here.
   assign last    = ({1'b0, pc_q} == (len_q - 1'b1));
   assign launch  = (state_q == S_IDLE) && bus.start && (bus.prog_len != '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = (bus.prog_len != '0) ? S_FETCH : S_DONE;
         end
         S_FETCH: state_d = S_EXEC;
         S_EXEC:  state_d = is_halt ? S_DONE : S_WB;
         S_WB: begin
            if (last)         state_d = S_DONE;
            else if (step_ok) state_d = S_FETCH;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         ir       <= '0;
         pc_q     <= '0;
         len_q    <= '0;
         reg_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         // Write enable only on entry to WB, so a step-stalled WB does not rewrite.
         reg_we_q <= (state_d == S_WB) && (state_q != S_WB);
         if (launch) begin
            len_q <= bus.prog_len;
            pc_q  <= '0;
         end
         if (state_q == S_FETCH) ir <= mem[pc_q];
         if ((state_q == S_WB) && !last && step_ok) pc_q <= pc_q + 1'b1;
      end
   end

   // Program memory is not reset; loads are refused while a run is in flight.
   always_ff @(posedge clk) begin
      if (bus.prog_we && !busy) mem[bus.prog_addr] <= bus.prog_data;
   end

   assign bus.busy      = busy;
   assign bus.done      = (state_q == S_DONE);
   assign bus.pc        = pc_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.alu_func  = ir[INSTR_W-1 -: FUNC_W];
   assign bus.rd_addr   = ir[3*RA_W-1 -: RA_W];
   assign bus.rs1_addr  = ir[2*RA_W-1 -: RA_W];
   assign bus.rs2_addr  = ir[RA_W-1:0];
   assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed programs plus random programs
// checked against a per-instruction timing model. Step test runs when ALU_SEQ_STEP_EN is defined.
module tb_alu_op_sequencer;
   localparam int W = 28;
   typedef logic [W-1:0] word_t;
   localparam logic [3:0] HALT = 4'hF;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;
   logic [15:0] mem_m [16];
   logic [3:0]  last_pc;
   logic [W-1:0] exp_q [$];

   alu_op_sequencer_if bus ();

   alu_op_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input word_t got, input word_t exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic prog_write(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.prog_we   = 1'b1;
      bus.prog_addr = a;
      bus.prog_data = d;
      mem_m[a]      = d;
      @(negedge clk);
      bus.prog_we   = 1'b0;
   endtask

   task automatic load_prog_a();
      prog_write(4'd0, 16'h0123);
      prog_write(4'd1, 16'h1415);
      prog_write(4'd2, 16'h2612);
   endtask

   // Model: instruction i fetches in cycle 3i+1, executes in 3i+2, writes back in 3i+3;
   // done follows the last writeback, or replaces the writeback of a halt.
   task automatic run_prog(input int len, input bit noise);
      int          done_cyc;
      logic [3:0]  end_pc;
      logic [15:0] ins;
      bit          seen;
      exp_q.delete();
      done_cyc = 1;
      end_pc   = last_pc;
      for (int i = 0; i < len; i++) begin
         ins    = mem_m[i];
         end_pc = 4'(i);
         if (ins[15:12] == HALT) begin
            done_cyc = 3*i + 3;
            break;
         end
         exp_q.push_back({8'(3*i + 3), 4'(i), ins});
         done_cyc = 3*i + 4;
      end

      @(negedge clk);
      bus.prog_len = 5'(len);
      bus.start    = 1'b1;
      seen = 1'b0;
      for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
         @(negedge clk);
         bus.start   = 1'b0;
         bus.prog_we = 1'b0;
         if (bus.reg_we) begin
            if (exp_q.size() == 0)
               check("extra_we", {8'(cyc), bus.pc, bus.alu_func, bus.rd_addr, bus.rs1_addr, bus.rs2_addr}, '0);
            else
               check("we_event", {8'(cyc), bus.pc, bus.alu_func, bus.rd_addr, bus.rs1_addr, bus.rs2_addr},
                     exp_q.pop_front());
         end
         check("busy", word_t'(bus.busy), word_t'(len > 0 && cyc < done_cyc));
         check("done", word_t'(bus.done), word_t'(cyc == done_cyc));
         if (bus.done) begin
            seen = 1'b1;
            check("pc_at_done", word_t'(bus.pc), word_t'(end_pc));
         end
         // Inputs set now are sampled at the next edge, while still busy: must be ignored.
         if (noise && len > 0 && cyc < done_cyc) begin
            bus.start     = 1'($urandom_range(0, 1));
            bus.prog_we   = 1'($urandom_range(0, 1));
            bus.prog_addr = 4'($urandom_range(0, 1));
            bus.prog_data = 16'($urandom);
         end
      end
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      if (!seen) check("done_timeout", '0, 1);
      check("we_leftover", word_t'(exp_q.size()), '0);
      last_pc = end_pc;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      last_pc = '0;
      rst = 1'b0;
      bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
      bus.prog_len = '0; bus.start = 1'b0;
`ifdef ALU_SEQ_STEP_EN
      bus.step = 1'b1;
`endif
      repeat (3) @(negedge clk);
      check("reset_outputs", {bus.busy, bus.done, bus.reg_we, bus.pc, bus.alu_func,
                              bus.rd_addr, bus.rs1_addr, bus.rs2_addr}, '0);
      rst = 1'b1;
      for (int a = 0; a < 16; a++) prog_write(4'(a), 16'($urandom));

      // Three-instruction program, no halt.
      load_prog_a();
      run_prog(3, 1'b0);

      // Halt in the second slot ends the run with pc=1.
      prog_write(4'd0, 16'h0123);
      prog_write(4'd1, 16'hF000);
      prog_write(4'd2, 16'h1222);
      run_prog(3, 1'b0);

      // Empty program: immediate done, pc keeps its previous value.
      run_prog(0, 1'b0);

      // Loads and starts while busy are ignored; two runs must match the model.
      load_prog_a();
      run_prog(3, 1'b1);
      run_prog(3, 1'b1);

      // Random programs, random lengths, then a full-depth run without halts.
      for (int r = 0; r < 6; r++) begin
         for (int a = 0; a < 16; a++) prog_write(4'(a), 16'($urandom));
         run_prog(int'($urandom_range(1, 16)), 1'b1);
      end
      for (int a = 0; a < 16; a++)
         prog_write(4'(a), {4'($urandom_range(0, 14)), 12'($urandom)});
      run_prog(16, 1'b0);

      // Reset during EXEC of the second instruction aborts the run.
      load_prog_a();
      @(negedge clk);
      bus.prog_len = 5'd3;
      bus.start    = 1'b1;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst = 1'b0;
      #1;
      check("abort_outputs", {bus.busy, bus.done, bus.reg_we, bus.pc, bus.alu_func,
                              bus.rd_addr, bus.rs1_addr, bus.rs2_addr}, '0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("abort_hold", word_t'({bus.busy, bus.done, bus.reg_we}), '0);
      end
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("abort_after", word_t'({bus.busy, bus.done, bus.reg_we}), '0);
      end
      last_pc = '0;
      run_prog(3, 1'b0);

`ifdef ALU_SEQ_STEP_EN
      // Step held low stalls in WB after one writeback; a step pulse resumes.
      load_prog_a();
      @(negedge clk);
      bus.step     = 1'b0;
      bus.prog_len = 5'd3;
      bus.start    = 1'b1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (cyc == 3) check("step_we1", word_t'(bus.reg_we), 1);
         else if (cyc == 11) check("step_we2", word_t'({bus.reg_we, bus.rd_addr}), word_t'(5'h14));
         else check("step_we_low", word_t'(bus.reg_we), '0);
         if (cyc >= 4 && cyc <= 8) check("step_hold", word_t'({bus.busy, bus.pc}), word_t'(5'h10));
         if (cyc == 8) bus.step = 1'b1;
         if (cyc == 9) begin
            bus.step = 1'b0;
            check("step_pc1", word_t'(bus.pc), 1);
         end
      end
      bus.step = 1'b1;
      begin
         bit seen_done;
         seen_done = 1'b0;
         for (int k = 0; k < 20 && !seen_done; k++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
         end
         if (!seen_done) check("step_timeout", '0, 1);
         else check("step_pc_done", word_t'(bus.pc), 2);
      end
      last_pc = 4'd2;
`endif

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Parametrised micro-sequencer that replaces fixed code-to-operation decoding with a loadable program memory.
- Steps through the stored instructions one at a time. For each, it drives the register-bank read/write addresses, the ALU function code and the register-bank write enable.
- Sits between the top-level test harness and the existing REG_BANK / K_ALU_32 pair, and owns the execution sequence.
- Uses a start/busy/done handshake so the caller can launch a program and detect its completion.

Parameters:
- FUNC_W, 4: ALU function-code width.
- RA_W, 4: register-address width (bank holds 2**RA_W registers).
- DEPTH, 16: program-memory entries. Must be a power of two, at least 2.
- PC_W, $clog2(DEPTH): program-counter width (derived).
- HALT_FUNC, 4'b1111: function code that terminates the program. Width is FUNC_W.

Instruction word: INSTR_W = FUNC_W + 3*RA_W (16 at defaults), fields {func, rd, rs1, rs2}, MSB first.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- prog_we  in  1  program-memory write strobe.
- prog_addr  in  PC_W  program-memory write address.
- prog_data  in  INSTR_W  instruction to store.
- prog_len  in  PC_W+1  number of instructions to run, 0..DEPTH. Sampled on start.
- start  in  1  launch request.
- busy  out  1  high while the sequence runs.
- done  out  1  single-cycle completion pulse.
- pc  out  PC_W  index of the current instruction.
- alu_func  out  FUNC_W  ALU function for the current instruction.
- rd_addr  out  RA_W  destination register.
- rs1_addr  out  RA_W  source register 1.
- rs2_addr  out  RA_W  source register 2.
- reg_we  out  1  register-bank write enable.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - pc, alu_func, rd_addr, rs1_addr, rs2_addr, the instruction register (ir) and the latched length all clear to 0.
  - busy, done and reg_we go to 0.
  - Program memory is not cleared; its contents are undefined until written.
- Program memory:
  - Synchronous write when prog_we=1 and busy=0.
  - Writes with busy=1 are dropped.
  - prog_addr >= DEPTH cannot occur, since the address is PC_W wide.
- State machine: IDLE -> FETCH -> EXEC -> WB -> (FETCH | DONE) -> IDLE.
- IDLE:
  - start=1 with prog_len>0: latch prog_len, set pc=0, go to FETCH.
  - start=1 with prog_len=0: go straight to DONE; no write occurs.
  - start is ignored in every other state.
- FETCH: ir <= mem[pc]; busy=1.
- EXEC:
  - Address/function outputs reflect ir and stay stable through WB.
  - If ir.func == HALT_FUNC, go to DONE without writeback.
  - Otherwise go to WB.
- WB:
  - reg_we=1 for exactly this cycle.
  - If pc == len-1, go to DONE.
  - Otherwise pc <= pc+1 and go to FETCH.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
  - pc holds its last value until the next start.
- Timing:
  - 3 cycles per instruction.
  - With start sampled at edge 0 and N instructions without halt: reg_we is high in cycles 3, 6, ..., 3N, and done is high in cycle 3N+1.
- pc never wraps. The last index is len-1, so at len=DEPTH the run ends at pc=DEPTH-1.
- A reset during any state aborts the run immediately. No further reg_we pulse or done pulse is produced.

Optional Feature:
- Macro: ALU_SEQ_STEP_EN.
- When defined:
  - An extra input port step (1 bit) exists.
  - The WB->FETCH transition is taken only in a cycle with step=1; otherwise the block waits in WB with reg_we=0 after the first WB cycle.
  - reg_we still pulses once per instruction.
  - The WB->DONE transition is unaffected by step.
- When undefined: no step port, and the block free-runs as described above.

Test Plan:
- Load {0,1,2,3}, {1,4,1,5}, {2,6,1,2}; prog_len=3; pulse start -> reg_we high in cycles 3, 6, 9 with rd_addr=1, 4, 6 and alu_func=0, 1, 2; done pulse in cycle 10; busy high in cycles 1-9.
- Load {0,1,2,3}, {F,0,0,0}, {1,2,2,2}; prog_len=3 -> exactly one reg_we pulse (cycle 3); done in cycle 6; pc=1 at done.
- prog_len=0; start -> done in cycle 1; reg_we never asserts; busy stays 0.
- During a run, prog_we=1 to address 0 with new data -> memory unchanged. A second run produces the same outputs as the first; start pulses while busy have no effect.
- Assert rst in the EXEC of instruction 2 -> all outputs 0 immediately, no further reg_we or done pulse. Start after releasing reset -> the program reruns from pc=0.
- With ALU_SEQ_STEP_EN defined and step held 0 -> remains in WB after instruction 1 with one reg_we pulse. Pulsing step proceeds to FETCH of instruction 2.
